// File: rtl/mnpk_isa_pkg.sv
// Shared ISA definitions: opcode constants, operand-length decode and fetch-server states.
// Imported by the fetch server and the control unit so both agree on instruction lengths.
package mnpk_isa_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MVI   = 8'h01;
    localparam logic [7:0] OP_MOV   = 8'h02;
    localparam logic [7:0] OP_MVIB  = 8'h03;
    localparam logic [7:0] OP_LOAD  = 8'h04;
    localparam logic [7:0] OP_STORE = 8'h05;

    typedef enum logic {
        StBoot,
        StRun
    } fetch_state_e;

    // Operand bytes that follow the opcode; unknown opcodes behave like NOP.
    function automatic logic [3:0] op_extra_bytes(input logic [7:0] opcode);
        logic [3:0] n;
        case (opcode)
            OP_MVI:   n = 4'd2;
            OP_MOV:   n = 4'd1;
            OP_MVIB:  n = 4'd2;
            OP_LOAD:  n = 4'd2;
            OP_STORE: n = 4'd2;
            default:  n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/prog_fetch_server_if.sv
// Fetch-side bus: boot loader handshake, control-unit PC commands and fetch results.
interface prog_fetch_server_if #(
    parameter int unsigned AW = 8
);
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] pc_load_addr;
    logic [7:0]    rom_data;
    logic [3:0]    extra_bytes;
    logic [AW-1:0] pc;
    logic          running;
    logic          pc_wrap;
    logic          load_ovf;

    modport master (
        output ld_valid, ld_data, ld_last, reload, pc_inc, pc_load, pc_load_addr,
        input  ld_ready, rom_data, extra_bytes, pc, running, pc_wrap, load_ovf
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, pc_inc, pc_load, pc_load_addr,
        output ld_ready, rom_data, extra_bytes, pc, running, pc_wrap, load_ovf
    );
endinterface

// File: rtl/prog_ram.sv
// Program memory: one synchronous write port, one asynchronous read port, no reset.
module prog_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fetch_server.sv
// Instruction-fetch responder: boot-loads program memory, then serves bytes at the PC
// and tracks PC advance/jump commands from the control unit.
module prog_fetch_server
    import mnpk_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    prog_fetch_server_if.slave bus
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    fetch_state_e  state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   prog_len_q;
    logic          running_q;
    logic          pc_wrap_q;
    logic          load_ovf_q;

    logic          wr_en;
    logic [7:0]    ram_rdata;
    logic [7:0]    rom_byte;

    assign wr_en = (state_q == StBoot) && bus.ld_valid;

    prog_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr_q),
        .wdata(bus.ld_data),
        .raddr(pc_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            running_q  <= 1'b0;
            pc_wrap_q  <= 1'b0;
            load_ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    if (bus.ld_valid) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        // Hitting the last address ends the load even without ld_last.
                        if (bus.ld_last || (wr_ptr_q == LastAddr)) begin
                            state_q    <= StRun;
                            running_q  <= 1'b1;
                            pc_q       <= '0;
                            prog_len_q <= {1'b0, wr_ptr_q} + 1'b1;
                            if (!bus.ld_last) begin
                                load_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                StRun: begin
                    if (bus.reload) begin
                        state_q    <= StBoot;
                        running_q  <= 1'b0;
                        wr_ptr_q   <= '0;
                        prog_len_q <= '0;
                        pc_q       <= '0;
                    end else if (bus.pc_load) begin
                        pc_q <= bus.pc_load_addr;
                    end else if (bus.pc_inc) begin
                        pc_q <= pc_q + 1'b1;
                        if (pc_q == LastAddr) begin
                            pc_wrap_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StBoot;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Bytes past the loaded program read as NOP so stale memory is never executed.
    always_comb begin
        rom_byte = OP_NOP;
        if (running_q && ({1'b0, pc_q} < prog_len_q)) begin
            rom_byte = ram_rdata;
        end
    end

    assign bus.rom_data    = rom_byte;
    assign bus.extra_bytes = op_extra_bytes(rom_byte);
    assign bus.ld_ready    = (state_q == StBoot);
    assign bus.pc          = pc_q;
    assign bus.running     = running_q;
    assign bus.pc_wrap     = pc_wrap_q;
    assign bus.load_ovf    = load_ovf_q;

endmodule

// File: tb/tb_prog_fetch_server.sv
// Scoreboarded bench: stimulus advances a queue-based program model each clock and pushes the
// expected observation; a negedge monitor pops and compares against the DUT outputs.
module tb_prog_fetch_server;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [7:0]    rom;
        logic [3:0]    extra;
        logic          running;
        logic          ready;
        logic          wrap;
        logic          ovf;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_fetch_server_if #(.AW(AW)) bus ();

    prog_fetch_server #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the loaded program as a byte list plus PC and flags.
    byte unsigned m_prog[$];
    int           m_pc   = 0;
    bit           m_run  = 1'b0;
    bit           m_wrap = 1'b0;
    bit           m_ovf  = 1'b0;
    int unsigned  extra_tbl [6] = '{0, 2, 1, 2, 2, 2};

    obs_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e.running = m_run;
        e.ready   = !m_run;
        e.wrap    = m_wrap;
        e.ovf     = m_ovf;
        e.pc      = AW'(m_pc);
        e.rom     = (m_run && m_pc < m_prog.size()) ? m_prog[m_pc] : 8'h00;
        e.extra   = (e.rom < 6) ? 4'(extra_tbl[e.rom]) : 4'd0;
        return e;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_prog.delete();
            m_pc = 0; m_run = 0; m_wrap = 0; m_ovf = 0;
        end else if (!m_run) begin
            if (bus.ld_valid) begin
                m_prog.push_back(bus.ld_data);
                if (bus.ld_last || m_prog.size() == DEPTH) begin
                    m_run = 1;
                    m_pc  = 0;
                    if (!bus.ld_last) m_ovf = 1;
                end
            end
        end else if (bus.reload) begin
            m_run = 0;
            m_prog.delete();
            m_pc = 0;
        end else if (bus.pc_load) begin
            m_pc = int'(bus.pc_load_addr);
        end else if (bus.pc_inc) begin
            if (m_pc == DEPTH - 1) m_wrap = 1;
            m_pc = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        exp_q.push_back(model_out());
    endtask

    task automatic clear_inputs();
        bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0; bus.reload = 0;
        bus.pc_inc = 0; bus.pc_load = 0; bus.pc_load_addr = '0;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        bus.ld_valid = 1; bus.ld_data = d; bus.ld_last = last;
        tick();
        bus.ld_valid = 0; bus.ld_last = 0;
    endtask

    task automatic inc();
        bus.pc_inc = 1;
        tick();
        bus.pc_inc = 0;
    endtask

    task automatic jump(input int addr, input bit with_inc);
        bus.pc_load = 1; bus.pc_load_addr = AW'(addr); bus.pc_inc = with_inc;
        tick();
        bus.pc_load = 0; bus.pc_inc = 0;
    endtask

    task automatic do_reload();
        bus.reload = 1;
        tick();
        bus.reload = 0;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pc = bus.pc; a.rom = bus.rom_data; a.extra = bus.extra_bytes;
            a.running = bus.running; a.ready = bus.ld_ready;
            a.wrap = bus.pc_wrap; a.ovf = bus.load_ovf;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL obs@%0t: actual pc=%0d rom=%h extra=%0d run=%b rdy=%b wrap=%b ovf=%b required pc=%0d rom=%h extra=%0d run=%b rdy=%b wrap=%b ovf=%b",
                         $time, a.pc, a.rom, a.extra, a.running, a.ready, a.wrap, a.ovf,
                         e.pc, e.rom, e.extra, e.running, e.ready, e.wrap, e.ovf);
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        check("reset_ready", bus.ld_ready, 1);
        check("reset_pc", bus.pc, 0);
        rst = 0;

        // Basic load and stepping.
        load_byte(8'h01, 0); load_byte(8'h03, 0); load_byte(8'h5A, 1);
        check("load_running", bus.running, 1);
        check("load_rom0", bus.rom_data, 8'h01);
        check("load_extra0", bus.extra_bytes, 2);
        inc(); check("step_rom1", bus.rom_data, 8'h03);
        inc(); check("step_rom2", bus.rom_data, 8'h5A);
        check("step_extra2", bus.extra_bytes, 0);
        inc(); check("step_past_len", bus.rom_data, 8'h00);

        // Loader with gaps.
        do_reload();
        load_byte(8'h02, 0); tick(); tick(); load_byte(8'h07, 0); load_byte(8'h00, 1);
        check("gap_rom0", bus.rom_data, 8'h02);
        check("gap_extra0", bus.extra_bytes, 1);
        inc(); check("gap_rom1", bus.rom_data, 8'h07);

        // Jump priority and wrap.
        jump(5, 1); check("jump_prio", bus.pc, 5);
        jump(DEPTH - 1, 0); inc();
        check("wrap_pc", bus.pc, 0);
        check("wrap_flag", bus.pc_wrap, 1);

        // Overflow load: DEPTH bytes, no ld_last.
        do_reload();
        for (int i = 0; i < DEPTH; i++) load_byte(8'(i + 1), 0);
        check("ovf_running", bus.running, 1);
        check("ovf_flag", bus.load_ovf, 1);
        jump(DEPTH - 1, 0); check("ovf_last_byte", bus.rom_data, 8'(DEPTH));

        // Reset mid-load.
        do_reload();
        load_byte(8'h11, 0); load_byte(8'h22, 0);
        rst = 1; tick(); rst = 0;
        check("rst_ready", bus.ld_ready, 1);
        check("rst_flags", {bus.pc_wrap, bus.load_ovf}, 0);
        load_byte(8'h04, 1);
        check("rst_rom0", bus.rom_data, 8'h04);
        check("rst_extra0", bus.extra_bytes, 2);
        inc(); check("rst_rom1", bus.rom_data, 8'h00);

        // Randomized programs and run traffic.
        for (int it = 0; it < 40; it++) begin
            int len;
            if (m_run) do_reload();
            if ($urandom_range(0, 9) == 0) begin
                rst = 1; tick(); rst = 0;
            end
            len = $urandom_range(1, DEPTH);
            for (int b = 0; b < len && !m_run; b++) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.pc_inc = 1'($urandom); bus.pc_load = 1'($urandom);
                    tick();
                end
                bus.pc_inc = 1'($urandom); bus.pc_load = 1'($urandom);
                load_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
                          (b == len - 1) && (len < DEPTH || $urandom_range(0, 1) == 1));
                if (it % 7 == 3 && b == len / 2 && !m_run) begin
                    rst = 1; tick(); rst = 0;
                    break;
                end
            end
            clear_inputs();
            for (int c = 0; c < 30; c++) begin
                bus.pc_inc       = ($urandom_range(0, 1) == 1);
                bus.pc_load      = ($urandom_range(0, 5) == 0);
                bus.pc_load_addr = AW'($urandom_range(0, DEPTH - 1));
                bus.reload       = ($urandom_range(0, 39) == 0);
                tick();
            end
            clear_inputs();
        end

        @(negedge clk); @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
